// File: rtl/nios2_debug_slave_scan_master_pkg.sv
// Shared types and constants for the Nios II debug slave scan master.
// Holds the virtual TAP state encoding and the virtual IR opcodes.
package nios2_dbg_pkg;

    localparam int DR_W_DEF = 38;
    localparam int IR_W_DEF = 2;

    localparam logic [1:0] IR_OCI_MEM   = 2'b00;
    localparam logic [1:0] IR_BREAK     = 2'b01;
    localparam logic [1:0] IR_TRACE_CTL = 2'b10;
    localparam logic [1:0] IR_TRACE_MEM = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        UIR,
        CDR,
        SDR,
        UDR,
        RTI,
        RESP
    } scan_state_e;

endpackage

// File: rtl/nios2_debug_slave_scan_master_if.sv
// Command/response handshake bundle between the debug bridge
// and the scan master.
interface nios2_debug_slave_scan_master_if #(
    parameter int DR_W = 38,
    parameter int IR_W = 2
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_dr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DR_W-1:0] rsp_dr;
    logic [IR_W-1:0] rsp_ir_out;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );
endinterface

// File: rtl/nios2_debug_slave_scan_master_tck_gen.sv
// Gated TCK divider. rise/fall flag the clk cycle whose closing
// edge moves TCK 0->1 / 1->0; TCK is forced low when not running.
module nios2_debug_scan_tck_gen #(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic rise,
    output logic fall
);
    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          tck_q;
    logic          wrap;

    assign wrap = run && (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else if (!run) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else if (wrap) begin
            cnt_q <= '0;
            tck_q <= ~tck_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tck  = tck_q;
    assign rise = wrap & ~tck_q;
    assign fall = wrap & tck_q;
endmodule

// File: rtl/nios2_debug_slave_scan_master.sv
// Virtual-JTAG scan master: runs one UIR/CDR/SDR/UDR/RTI sequence
// per accepted command and returns the captured TDO word.
module nios2_debug_slave_scan_master
    import nios2_dbg_pkg::*;
#(
    parameter int DR_W     = DR_W_DEF,
    parameter int IR_W     = IR_W_DEF,
    parameter int HALF_DIV = 2,
    parameter int RTI_TCKS = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    nios2_debug_slave_scan_master_if.slave bus,
    output logic            busy,
    output logic            vji_tck,
    output logic            vji_tdi,
    input  logic            vji_tdo,
    output logic [IR_W-1:0] vji_ir_in,
    input  logic [IR_W-1:0] vji_ir_out,
    output logic            vji_uir,
    output logic            vji_cdr,
    output logic            vji_sdr,
    output logic            vji_udr,
    output logic            vji_rti
);
    localparam int BW = $clog2(DR_W);
    localparam int RW = (RTI_TCKS > 1) ? $clog2(RTI_TCKS) : 1;
    localparam logic [BW-1:0] BLAST = BW'(DR_W - 1);
    localparam logic [RW-1:0] RLAST = RW'(RTI_TCKS - 1);

    scan_state_e     state_q;
    logic [DR_W-1:0] shreg_q;
    logic [DR_W-1:0] cap_q;
    logic [IR_W-1:0] irout_q;
    logic [IR_W-1:0] irin_q;
    logic [BW-1:0]   bit_q;
    logic [RW-1:0]   rti_q;
    logic            tdi_q;
    logic            rdy_q;
    logic            rv_q;
    logic            uir_q, cdr_q, sdr_q, udr_q, rti_fl_q;
    logic            run, rise, fall;

    assign run = (state_q != IDLE) && (state_q != RESP);

    nios2_debug_scan_tck_gen #(.HALF_DIV(HALF_DIV)) u_tck (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .tck     (vji_tck),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cap_q    <= '0;
            irout_q  <= '0;
            irin_q   <= '0;
            bit_q    <= '0;
            rti_q    <= '0;
            tdi_q    <= 1'b0;
            rdy_q    <= 1'b0;
            rv_q     <= 1'b0;
            uir_q    <= 1'b0;
            cdr_q    <= 1'b0;
            sdr_q    <= 1'b0;
            udr_q    <= 1'b0;
            rti_fl_q <= 1'b0;
        end else begin
            if (rise && state_q == CDR)
                irout_q <= vji_ir_out;
            if (rise && state_q == SDR)
                cap_q <= {vji_tdo, cap_q[DR_W-1:1]};
            unique case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (bus.cmd_valid && rdy_q) begin
                        rdy_q   <= 1'b0;
                        irin_q  <= bus.cmd_ir;
                        shreg_q <= bus.cmd_dr;
                        bit_q   <= '0;
                        rti_q   <= '0;
                        uir_q   <= 1'b1;
                        state_q <= UIR;
                    end
                end
                UIR: if (fall) begin
                    uir_q   <= 1'b0;
                    cdr_q   <= 1'b1;
                    state_q <= CDR;
                end
                CDR: if (fall) begin
                    cdr_q   <= 1'b0;
                    sdr_q   <= 1'b1;
                    tdi_q   <= shreg_q[0];
                    shreg_q <= shreg_q >> 1;
                    state_q <= SDR;
                end
                SDR: if (fall) begin
                    if (bit_q == BLAST) begin
                        sdr_q   <= 1'b0;
                        udr_q   <= 1'b1;
                        state_q <= UDR;
                    end else begin
                        bit_q   <= bit_q + 1'b1;
                        tdi_q   <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                    end
                end
                UDR: if (fall) begin
                    udr_q    <= 1'b0;
                    rti_fl_q <= 1'b1;
                    state_q  <= RTI;
                end
                RTI: if (fall) begin
                    if (rti_q == RLAST) begin
                        rti_fl_q <= 1'b0;
                        rv_q     <= 1'b1;
                        state_q  <= RESP;
                    end else begin
                        rti_q <= rti_q + 1'b1;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    // ready rises with IDLE, so accept lands one clk later
                    rv_q    <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = (state_q != IDLE);
    assign bus.cmd_ready  = rdy_q;
    assign bus.rsp_valid  = rv_q;
    assign bus.rsp_dr     = cap_q;
    assign bus.rsp_ir_out = irout_q;
    assign vji_tdi        = tdi_q;
    assign vji_ir_in      = irin_q;
    assign vji_uir        = uir_q;
    assign vji_cdr        = cdr_q;
    assign vji_sdr        = sdr_q;
    assign vji_udr        = udr_q;
    assign vji_rti        = rti_fl_q;
endmodule
